// File: rtl/fs_pwm_pkg.sv
// Shared definitions for the PWM duty scheduler and the logic around it.
package fs_pwm_pkg;

  localparam int unsigned PW_WIDTH_DEF    = 4;
  localparam int unsigned PWM_PERIOD_CLKS = 2000;

  typedef enum logic [1:0] {
    StIdle,
    StRamp,
    StDone
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned PtrW    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PtrW-1:0]    i_ptr,
  output logic               o_valid,
  output logic [NUM_REQ-1:0] o_sel,
  output logic [PtrW-1:0]    o_idx,
  output logic [PtrW-1:0]    o_next_ptr
);

  logic [PtrW-1:0] w_pos;

  always_comb begin
    o_valid    = 1'b0;
    o_sel      = '0;
    o_idx      = '0;
    o_next_ptr = '0;
    w_pos      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = PtrW'((32'(i_ptr) + k) % NUM_REQ);
      if (!o_valid && i_req[w_pos]) begin
        o_valid      = 1'b1;
        o_sel[w_pos] = 1'b1;
        o_idx        = w_pos;
        o_next_ptr   = PtrW'((32'(w_pos) + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/pwm_duty_scheduler.sv
// Grants duty-change requests round-robin and ramps pulse_width one LSB per RAMP_DIV
// PWM periods, stepping only on clk_500Hz rising edges.
module pwm_duty_scheduler
  import fs_pwm_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned PW_WIDTH = PW_WIDTH_DEF,
  parameter int unsigned RAMP_DIV = 1
) (
  input  logic                         clk_1MHz,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*PW_WIDTH-1:0]  req_duty,
  input  logic                         clk_500Hz,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [PW_WIDTH-1:0]          pulse_width,
  output logic                         busy,
  output logic                         ramp_done
);

  localparam int unsigned PtrW = $clog2(NUM_REQ);
  localparam int unsigned CntW = 4;

  sched_state_e        r_state, w_state_next;
  logic [PtrW-1:0]     r_rr_ptr, w_rr_ptr_d;
  logic [CntW-1:0]     r_cnt, w_cnt_d;
  logic [PW_WIDTH-1:0] r_target, w_target_d;
  logic [PW_WIDTH-1:0] r_pw, w_pw_d;
  logic [NUM_REQ-1:0]  r_gnt, w_gnt_d;
  logic                r_busy, w_busy_d;
  logic                r_done, w_done_d;
  logic                r_clk_500_q;

  logic                w_bnd;
  logic                w_arb_valid;
  logic [NUM_REQ-1:0]  w_arb_sel;
  logic [PtrW-1:0]     w_arb_idx;
  logic [PtrW-1:0]     w_arb_next_ptr;
  logic [PW_WIDTH-1:0] w_grant_duty;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PtrW    (PtrW)
  ) u_rr_arbiter (
    .i_req      (req),
    .i_ptr      (r_rr_ptr),
    .o_valid    (w_arb_valid),
    .o_sel      (w_arb_sel),
    .o_idx      (w_arb_idx),
    .o_next_ptr (w_arb_next_ptr)
  );

  assign w_bnd        = clk_500Hz & ~r_clk_500_q;
  assign w_grant_duty = req_duty[w_arb_idx*PW_WIDTH +: PW_WIDTH];

  always_ff @(posedge clk_1MHz) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_arb_valid) w_state_next = StRamp;
      StRamp:  if (r_pw == r_target) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_gnt_d    = '0;
    w_done_d   = 1'b0;
    w_busy_d   = r_busy;
    w_pw_d     = r_pw;
    w_target_d = r_target;
    w_cnt_d    = r_cnt;
    w_rr_ptr_d = r_rr_ptr;
    unique case (r_state)
      StIdle: begin
        if (w_arb_valid) begin
          w_gnt_d    = w_arb_sel;
          w_target_d = w_grant_duty;
          w_rr_ptr_d = w_arb_next_ptr;
          w_cnt_d    = '0;
          w_busy_d   = 1'b1;
        end
      end
      StRamp: begin
        // A boundary coinciding with the grant pulse is not counted.
        if (w_bnd && r_gnt == '0 && r_pw != r_target) begin
          if (r_cnt == CntW'(RAMP_DIV - 1)) begin
            w_cnt_d = '0;
            w_pw_d  = (r_pw < r_target) ? r_pw + 1'b1 : r_pw - 1'b1;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      StDone: begin
        w_done_d = 1'b1;
        w_busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_1MHz) begin
    if (rst) begin
      r_gnt       <= '0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_pw        <= '0;
      r_target    <= '0;
      r_cnt       <= '0;
      r_rr_ptr    <= '0;
      r_clk_500_q <= 1'b1;
    end else begin
      r_gnt       <= w_gnt_d;
      r_done      <= w_done_d;
      r_busy      <= w_busy_d;
      r_pw        <= w_pw_d;
      r_target    <= w_target_d;
      r_cnt       <= w_cnt_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_clk_500_q <= clk_500Hz;
    end
  end

  assign gnt         = r_gnt;
  assign pulse_width = r_pw;
  assign busy        = r_busy;
  assign ramp_done   = r_done;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Directed bench for pwm_duty_scheduler: one instance with RAMP_DIV=1, one with RAMP_DIV=3.
module tb_pwm_duty_scheduler;
  import fs_pwm_pkg::*;

  // Shortened PWM period so the run stays small; the scheduler only sees edges.
  localparam int unsigned LoCycles = PWM_PERIOD_CLKS / 500;

  logic       clk = 1'b0;
  logic       rst;
  logic       c500;
  logic [1:0] req_a, req_b;
  logic [7:0] duty_a, duty_b;
  logic [1:0] gnt_a, gnt_b;
  logic [3:0] pw_a, pw_b;
  logic       busy_a, busy_b, done_a, done_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pwm_duty_scheduler #(.NUM_REQ(2), .PW_WIDTH(4), .RAMP_DIV(1)) dut_a (
    .clk_1MHz    (clk),
    .rst         (rst),
    .req         (req_a),
    .req_duty    (duty_a),
    .clk_500Hz   (c500),
    .gnt         (gnt_a),
    .pulse_width (pw_a),
    .busy        (busy_a),
    .ramp_done   (done_a)
  );

  pwm_duty_scheduler #(.NUM_REQ(2), .PW_WIDTH(4), .RAMP_DIV(3)) dut_b (
    .clk_1MHz    (clk),
    .rst         (rst),
    .req         (req_b),
    .req_duty    (duty_b),
    .clk_500Hz   (c500),
    .gnt         (gnt_b),
    .pulse_width (pw_b),
    .busy        (busy_b),
    .ramp_done   (done_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lo();
    c500 = 1'b0;
    repeat (LoCycles) tick();
  endtask

  // Rising clk_500Hz sampled at this edge; any step is visible on return.
  task automatic hi();
    c500 = 1'b1;
    tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [1:0] rr_exp [4];

  initial begin
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    rst = 1'b1; c500 = 1'b1;
    req_a = '0; req_b = '0; duty_a = '0; duty_b = '0;

    // Reset with clk_500Hz held high
    repeat (3) tick();
    check("rst_pw", 32'(pw_a), 0);
    check("rst_busy", 32'(busy_a), 0);
    check("rst_gnt", 32'(gnt_a), 0);
    check("rst_done", 32'(done_a), 0);
    rst = 1'b0;
    tick();
    check("rel_pw", 32'(pw_a), 0);
    check("rel_busy", 32'(busy_a), 0);
    tick();
    check("rel_pw2", 32'(pw_a), 0);

    // Single ramp up 0 -> 5, RAMP_DIV=1
    c500 = 1'b0;
    tick();
    req_a = 2'b01; duty_a = {4'd0, 4'd5};
    tick();
    check("s1_gnt", 32'(gnt_a), 32'b01);
    check("s1_busy", 32'(busy_a), 1);
    check("s1_pw0", 32'(pw_a), 0);
    req_a = '0;
    tick();
    check("s1_gnt_pulse", 32'(gnt_a), 0);
    for (int n = 1; n <= 5; n++) begin
      lo();
      check("s1_hold", 32'(pw_a), 32'(n - 1));
      hi();
      check("s1_step", 32'(pw_a), 32'(n));
    end
    check("s1_done_early", 32'(done_a), 0);
    check("s1_busy_ramp", 32'(busy_a), 1);
    tick();
    check("s1_done_wait", 32'(done_a), 0);
    tick();
    check("s1_done", 32'(done_a), 1);
    check("s1_busy_fall", 32'(busy_a), 0);
    tick();
    check("s1_done_pulse", 32'(done_a), 0);

    // RAMP_DIV=3: bring B to 8, then ramp 8 -> 6 from requester 1
    req_b = 2'b01; duty_b = {4'd0, 4'd8};
    tick();
    check("s2_gnt0", 32'(gnt_b), 32'b01);
    req_b = '0;
    repeat (24) begin
      lo();
      hi();
    end
    check("s2_pw8", 32'(pw_b), 8);
    tick();
    tick();
    check("s2_done_up", 32'(done_b), 1);
    req_b = 2'b10; duty_b = {4'd6, 4'd0};
    tick();
    check("s2_gnt1", 32'(gnt_b), 32'b10);
    req_b = '0;
    for (int n = 1; n <= 6; n++) begin
      lo();
      hi();
      check("s2_down", 32'(pw_b), 32'(8 - n / 3));
    end
    check("s2_busy", 32'(busy_b), 1);
    tick();
    tick();
    check("s2_done", 32'(done_b), 1);
    check("s2_busy_fall", 32'(busy_b), 0);

    // Bring A down to 3 via requester 1, then round-robin with zero-length ramps
    req_a = 2'b10; duty_a = {4'd3, 4'd0};
    tick();
    check("s3_prep_gnt", 32'(gnt_a), 32'b10);
    req_a = '0;
    lo(); hi();
    check("s3_prep_pw4", 32'(pw_a), 4);
    lo(); hi();
    check("s3_prep_pw3", 32'(pw_a), 3);
    tick();
    tick();
    check("s3_prep_done", 32'(done_a), 1);
    req_a = 2'b11; duty_a = {4'd3, 4'd3};
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s3_rr_gnt", 32'(gnt_a), 32'(rr_exp[i]));
      tick();
      check("s3_rr_gap", 32'(gnt_a), 0);
      check("s3_rr_nodone", 32'(done_a), 0);
      tick();
      check("s3_rr_done", 32'(done_a), 1);
      if (i == 3) req_a = '0;
    end

    // Request from requester 1 arriving mid-ramp of requester 0 (3 -> 6)
    req_a = 2'b01; duty_a = {4'd3, 4'd6};
    tick();
    check("s4_gnt0", 32'(gnt_a), 32'b01);
    req_a = '0;
    lo(); hi();
    check("s4_pw4", 32'(pw_a), 4);
    req_a = 2'b10;
    lo();
    check("s4_nogrant_lo", 32'(gnt_a), 0);
    hi();
    check("s4_pw5", 32'(pw_a), 5);
    lo(); hi();
    check("s4_pw6", 32'(pw_a), 6);
    check("s4_nogrant_ramp", 32'(gnt_a), 0);
    tick();
    check("s4_nogrant_done", 32'(gnt_a), 0);
    tick();
    check("s4_done", 32'(done_a), 1);
    check("s4_nogrant_rd", 32'(gnt_a), 0);
    tick();
    check("s4_gnt1", 32'(gnt_a), 32'b10);

    // Reset mid-ramp: 2 -> 9 interrupted at 5, requester 1 pending
    rst = 1'b1; req_a = '0;
    tick();
    rst = 1'b0;
    check("s5_rst_pw", 32'(pw_a), 0);
    req_a = 2'b01; duty_a = {4'd7, 4'd2};
    tick();
    check("s5_gnt_to2", 32'(gnt_a), 32'b01);
    req_a = '0;
    lo(); hi(); lo(); hi();
    check("s5_pw2", 32'(pw_a), 2);
    tick();
    tick();
    check("s5_done2", 32'(done_a), 1);
    req_a = 2'b01; duty_a = {4'd7, 4'd9};
    tick();
    check("s5_gnt_to9", 32'(gnt_a), 32'b01);
    req_a = 2'b10;
    lo(); hi(); lo(); hi(); lo(); hi();
    check("s5_pw5", 32'(pw_a), 5);
    check("s5_busy", 32'(busy_a), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("s5_mid_pw", 32'(pw_a), 0);
    check("s5_mid_busy", 32'(busy_a), 0);
    check("s5_mid_gnt", 32'(gnt_a), 0);
    tick();
    check("s5_regrant", 32'(gnt_a), 32'b10);
    check("s5_regrant_busy", 32'(busy_a), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
